// File: rtl/sd_spi_controller.sv
`default_nettype none
// ============================================================================
// Module      : sd_spi_controller
// Description : CPU-port SPI master for SD cards. Provides a TX holding
//               register, an RX register, slow/fast SCLK selection, two
//               card selects and a status byte. One byte per transfer,
//               MSB first, SPI mode 0 (SCLK idle low, MISO sampled on the
//               rising SCLK edge).
// Ports       : clock             - system clock
//               reset_n           - asynchronous active-low reset
//               cpuDataOut[7:0]   - CPU write data
//               DataToSD_cs       - write TX holding register
//               DataFmSD_cs       - read RX register
//               SD_Clk_cs         - write speed (D0=1 fast)
//               SD_Card_select_cs - write card select (D0 card A, D1 card B)
//               SD_status_cs      - read status
//               SDWrite_cs        - start transfer of TX holding register
//               SDRead_cs         - start transfer of 0xFF
//               spi_miso          - SD data in
//               sdDataIn[7:0]     - CPU read data
//               spi_sclk          - SPI clock
//               spi_mosi          - SPI data out
//               sd_cs_a_n         - card A select, active low
//               sd_cs_b_n         - card B select, active low
//               busy              - transfer in progress
// Revision    : 1.0 - initial release
// ============================================================================
module sd_spi_controller #(
    parameter int SLOW_DIV = 124,
    parameter int FAST_DIV = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] cpuDataOut,
    input  logic       DataToSD_cs,
    input  logic       DataFmSD_cs,
    input  logic       SD_Clk_cs,
    input  logic       SD_Card_select_cs,
    input  logic       SD_status_cs,
    input  logic       SDWrite_cs,
    input  logic       SDRead_cs,
    input  logic       spi_miso,
    output logic [7:0] sdDataIn,
    output logic       spi_sclk,
    output logic       spi_mosi,
    output logic       sd_cs_a_n,
    output logic       sd_cs_b_n,
    output logic       busy
);

    localparam int c_MAX_DIV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
    localparam int c_DIV_W   = (c_MAX_DIV < 2) ? 1 : $clog2(c_MAX_DIV + 1);
    localparam logic [c_DIV_W-1:0] c_SLOW = c_DIV_W'(SLOW_DIV);
    localparam logic [c_DIV_W-1:0] c_FAST = c_DIV_W'(FAST_DIV);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    // Previous-cycle copies of the write/start chip selects
    logic r_dataToSdPrev;
    logic r_clkSelPrev;
    logic r_cardSelPrev;
    logic r_writePrev;
    logic r_readPrev;

    // Configuration registers
    logic [7:0] r_txHold;
    logic       r_fast;
    logic       r_csAN;
    logic       r_csBN;

    // Transfer engine
    state_t             r_state;
    logic [c_DIV_W-1:0] r_curDiv;
    logic [c_DIV_W-1:0] r_divCnt;
    logic [2:0]         r_bitCnt;
    logic [7:0]         r_txShift;
    logic [7:0]         r_rxShift;
    logic [7:0]         r_rx;
    logic               r_sclk;
    logic               r_mosi;
    logic               r_busy;

    logic       w_txLoad;
    logic       w_clkLoad;
    logic       w_cardLoad;
    logic       w_writeStart;
    logic       w_readStart;
    logic [7:0] w_status;

    // Each chip select is a level lasting a whole I/O cycle; act only on
    // its first clock.
    assign w_txLoad     = DataToSD_cs       & ~r_dataToSdPrev;
    assign w_clkLoad    = SD_Clk_cs         & ~r_clkSelPrev;
    assign w_cardLoad   = SD_Card_select_cs & ~r_cardSelPrev;
    assign w_writeStart = SDWrite_cs        & ~r_writePrev;
    assign w_readStart  = SDRead_cs         & ~r_readPrev;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_dataToSdPrev <= 1'b0;
            r_clkSelPrev   <= 1'b0;
            r_cardSelPrev  <= 1'b0;
            r_writePrev    <= 1'b0;
            r_readPrev     <= 1'b0;
        end else begin
            r_dataToSdPrev <= DataToSD_cs;
            r_clkSelPrev   <= SD_Clk_cs;
            r_cardSelPrev  <= SD_Card_select_cs;
            r_writePrev    <= SDWrite_cs;
            r_readPrev     <= SDRead_cs;
        end
    end

    // Configuration writes are accepted at any time, busy or not. The
    // holding register is separate from the shifter, so a write here never
    // disturbs a byte already being shifted out.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_txHold <= 8'hFF;
            r_fast   <= 1'b0;
            r_csAN   <= 1'b1;
            r_csBN   <= 1'b1;
        end else begin
            if (w_txLoad) begin
                r_txHold <= cpuDataOut;
            end
            if (w_clkLoad) begin
                r_fast <= cpuDataOut[0];
            end
            if (w_cardLoad) begin
                // Only a single selected card is meaningful; 00 and 11
                // both deselect everything.
                r_csAN <= ~(cpuDataOut[1:0] == 2'b01);
                r_csBN <= ~(cpuDataOut[1:0] == 2'b10);
            end
        end
    end

    // Transfer FSM. SCLK, MOSI and busy are registered here so the pins
    // are glitch-free.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_curDiv  <= c_SLOW;
            r_divCnt  <= '0;
            r_bitCnt  <= 3'd0;
            r_txShift <= 8'hFF;
            r_rxShift <= 8'hFF;
            r_rx      <= 8'hFF;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // A simultaneous write and read start is a write.
                    if (w_writeStart || w_readStart) begin
                        r_txShift <= w_writeStart ? r_txHold : 8'hFF;
                        r_mosi    <= w_writeStart ? r_txHold[7] : 1'b1;
                        // Speed is latched here so a mid-transfer speed
                        // change waits for the next byte.
                        r_curDiv  <= r_fast ? c_FAST : c_SLOW;
                        r_divCnt  <= '0;
                        r_bitCnt  <= 3'd0;
                        r_sclk    <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= LOW;
                    end
                end
                LOW: begin
                    if (r_divCnt == r_curDiv) begin
                        // Sample MISO on the clock that raises SCLK.
                        r_divCnt  <= '0;
                        r_rxShift <= {r_rxShift[6:0], spi_miso};
                        r_sclk    <= 1'b1;
                        r_state   <= HIGH;
                    end else begin
                        r_divCnt <= r_divCnt + 1'b1;
                    end
                end
                HIGH: begin
                    if (r_divCnt == r_curDiv) begin
                        r_divCnt  <= '0;
                        r_txShift <= {r_txShift[6:0], 1'b1};
                        r_sclk    <= 1'b0;
                        if (r_bitCnt == 3'd7) begin
                            r_mosi  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            // Next bit goes out with the falling SCLK edge.
                            r_bitCnt <= r_bitCnt + 3'd1;
                            r_mosi   <= r_txShift[6];
                            r_state  <= LOW;
                        end
                    end else begin
                        r_divCnt <= r_divCnt + 1'b1;
                    end
                end
                DONE: begin
                    r_rx    <= r_rxShift;
                    r_mosi  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign w_status = {4'b0000, r_fast, ~r_csBN, ~r_csAN, r_busy};

    always_comb begin
        sdDataIn = 8'h00;
        if (DataFmSD_cs) begin
            sdDataIn = r_rx;
        end else if (SD_status_cs) begin
            sdDataIn = w_status;
        end
    end

    assign spi_sclk  = r_sclk;
    assign spi_mosi  = r_mosi;
    assign sd_cs_a_n = r_csAN;
    assign sd_cs_b_n = r_csBN;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sd_spi_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_sd_spi_controller
// Description : Self-checking bench for sd_spi_controller. A small SPI slave
//               model drives MISO from a chosen byte and records MOSI on
//               each rising SCLK; a behavioural model tracks the CPU-visible
//               registers and predicts every transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_spi_controller;

    localparam int SLOW_DIV = 124;
    localparam int FAST_DIV = 1;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] cpuDataOut;
    logic       DataToSD_cs, DataFmSD_cs, SD_Clk_cs, SD_Card_select_cs;
    logic       SD_status_cs, SDWrite_cs, SDRead_cs;
    wire        spi_miso;
    wire [7:0]  sdDataIn;
    wire        spi_sclk, spi_mosi, sd_cs_a_n, sd_cs_b_n, busy;

    always #5 clock = ~clock;

    sd_spi_controller #(.SLOW_DIV(SLOW_DIV), .FAST_DIV(FAST_DIV)) dut (
        .clock(clock), .reset_n(reset_n), .cpuDataOut(cpuDataOut),
        .DataToSD_cs(DataToSD_cs), .DataFmSD_cs(DataFmSD_cs),
        .SD_Clk_cs(SD_Clk_cs), .SD_Card_select_cs(SD_Card_select_cs),
        .SD_status_cs(SD_status_cs), .SDWrite_cs(SDWrite_cs),
        .SDRead_cs(SDRead_cs), .spi_miso(spi_miso), .sdDataIn(sdDataIn),
        .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .sd_cs_a_n(sd_cs_a_n),
        .sd_cs_b_n(sd_cs_b_n), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model of the CPU-visible state
    logic [7:0] mTx  = 8'hFF;
    logic [7:0] mRx  = 8'hFF;
    logic       mFast = 1'b0;
    logic       mSelA = 1'b0;
    logic       mSelB = 1'b0;

    // SPI slave model and observation counters
    logic [7:0] slaveByte = 8'hFF;
    int         slaveIdx  = 8;
    logic [7:0] mosiCap   = 8'h00;
    int         rises = 0, busyCnt = 0, sclkHighCnt = 0, mosiLowCnt = 0, starts = 0;
    logic       prevBusy = 1'b0;

    assign spi_miso = (slaveIdx < 8) ? slaveByte[7 - slaveIdx] : 1'b1;

    always @(posedge spi_sclk) begin
        mosiCap  = {mosiCap[6:0], spi_mosi};
        rises    = rises + 1;
        slaveIdx = slaveIdx + 1;
    end

    always @(negedge clock) begin
        if (busy) busyCnt = busyCnt + 1;
        if (busy && spi_sclk) sclkHighCnt = sclkHighCnt + 1;
        if (busy && !spi_mosi) mosiLowCnt = mosiLowCnt + 1;
        if (busy && !prevBusy) starts = starts + 1;
        prevBusy = busy;
    end

    function automatic int curDiv();
        return mFast ? FAST_DIV : SLOW_DIV;
    endfunction

    function automatic logic [7:0] expStatus(input logic b);
        return {4'b0000, mFast, mSelB, mSelA, b};
    endfunction

    // port: 0 TX hold, 1 speed, 2 card select, 3 write start,
    //       4 read start, 5 write+read start together
    task automatic setCs(input int port, input logic v);
        case (port)
            0: DataToSD_cs = v;
            1: SD_Clk_cs = v;
            2: SD_Card_select_cs = v;
            3: SDWrite_cs = v;
            4: SDRead_cs = v;
            default: begin SDWrite_cs = v; SDRead_cs = v; end
        endcase
    endtask

    task automatic ioWrite(input int port, input logic [7:0] d, input int hold);
        @(negedge clock);
        cpuDataOut = d;
        setCs(port, 1'b1);
        repeat (hold) @(negedge clock);
        setCs(port, 1'b0);
    endtask

    task automatic readPort(input logic status, output logic [7:0] v);
        DataFmSD_cs  = ~status;
        SD_status_cs = status;
        #1;
        v = sdDataIn;
        DataFmSD_cs  = 1'b0;
        SD_status_cs = 1'b0;
    endtask

    task automatic waitIdle(input int bound);
        int n = 0;
        while (busy && n < bound) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL waitIdle timeout: busy=%b after %0d cycles, required 0", busy, n);
        end
    endtask

    task automatic armSlave(input logic [7:0] b);
        slaveByte = b; slaveIdx = 0; rises = 0; busyCnt = 0;
        sclkHighCnt = 0; mosiLowCnt = 0;
    endtask

    // Starts a transfer and waits for it to finish; observations are left
    // in the counters and mosiCap for the caller to judge.
    task automatic runXfer(input int kind, input logic [7:0] misoByte);
        armSlave(misoByte);
        ioWrite(kind, 8'h00, 2);
        waitIdle(16 * (curDiv() + 1) + 20);
    endtask

    task automatic test_reset();
        logic [7:0] v;
        @(negedge clock);
        checks++;
        if ({busy, spi_sclk, spi_mosi, sd_cs_a_n, sd_cs_b_n} !== 5'b00111) begin
            errors++;
            $display("FAIL reset_pins: got %b, required 00111",
                     {busy, spi_sclk, spi_mosi, sd_cs_a_n, sd_cs_b_n});
        end
        readPort(1'b1, v);
        checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL reset_status: got %h, required 00", v); end
        readPort(1'b0, v);
        checks++;
        if (v !== 8'hFF) begin errors++; $display("FAIL reset_rx: got %h, required ff", v); end
        #1;
        checks++;
        if (sdDataIn !== 8'h00) begin errors++; $display("FAIL idle_bus: got %h, required 00", sdDataIn); end
    endtask

    task automatic test_slow_write();
        logic [7:0] v;
        ioWrite(0, 8'hA5, 2); mTx = 8'hA5;
        runXfer(3, 8'h3C); mRx = 8'h3C;
        checks++;
        if (mosiCap !== mTx) begin errors++; $display("FAIL slow_mosi: got %h, required %h", mosiCap, mTx); end
        checks++;
        if (busyCnt !== 16 * (SLOW_DIV + 1) + 1) begin
            errors++; $display("FAIL slow_busy: got %0d, required %0d", busyCnt, 16 * (SLOW_DIV + 1) + 1);
        end
        checks++;
        if (rises !== 8) begin errors++; $display("FAIL slow_rises: got %0d, required 8", rises); end
        readPort(1'b0, v);
        checks++;
        if (v !== mRx) begin errors++; $display("FAIL slow_rx: got %h, required %h", v, mRx); end
    endtask

    task automatic test_fast_read();
        logic [7:0] v;
        ioWrite(1, 8'h01, 2); mFast = 1'b1;
        @(negedge clock);
        readPort(1'b1, v);
        checks++;
        if (v !== expStatus(1'b0)) begin errors++; $display("FAIL fast_status: got %h, required %h", v, expStatus(1'b0)); end
        runXfer(4, 8'h00); mRx = 8'h00;
        checks++;
        if (mosiLowCnt !== 0 || mosiCap !== 8'hFF) begin
            errors++; $display("FAIL fast_mosi: low cycles %0d byte %h, required 0 and ff", mosiLowCnt, mosiCap);
        end
        checks++;
        if (busyCnt !== 16 * (FAST_DIV + 1) + 1) begin
            errors++; $display("FAIL fast_busy: got %0d, required %0d", busyCnt, 16 * (FAST_DIV + 1) + 1);
        end
        checks++;
        if (rises !== 8 || sclkHighCnt !== 8 * (FAST_DIV + 1)) begin
            errors++; $display("FAIL fast_sclk: rises %0d high %0d, required 8 and %0d", rises, sclkHighCnt, 8 * (FAST_DIV + 1));
        end
        readPort(1'b0, v);
        checks++;
        if (v !== mRx) begin errors++; $display("FAIL fast_rx: got %h, required %h", v, mRx); end
    endtask

    task automatic test_card_select();
        logic [7:0] v;
        logic [7:0] sel [3] = '{8'h01, 8'h02, 8'h03};
        for (int i = 0; i < 3; i++) begin
            ioWrite(2, sel[i], 2);
            mSelA = (sel[i][1:0] == 2'b01);
            mSelB = (sel[i][1:0] == 2'b10);
            @(negedge clock);
            checks++;
            if ({sd_cs_a_n, sd_cs_b_n} !== {~mSelA, ~mSelB}) begin
                errors++; $display("FAIL card_pins[%0d]: got %b, required %b", i, {sd_cs_a_n, sd_cs_b_n}, {~mSelA, ~mSelB});
            end
            readPort(1'b1, v);
            checks++;
            if (v !== expStatus(1'b0)) begin errors++; $display("FAIL card_status[%0d]: got %h, required %h", i, v, expStatus(1'b0)); end
        end
    endtask

    task automatic test_busy_ignore();
        logic [7:0] v;
        logic [7:0] first;
        int s0;
        first = 8'($urandom);
        ioWrite(0, first, 1); mTx = first;
        s0 = starts;
        armSlave(8'($urandom));
        ioWrite(3, 8'h00, 1);
        ioWrite(3, 8'h00, 1);
        ioWrite(4, 8'h00, 1);
        ioWrite(0, 8'h11, 1); mTx = 8'h11;
        @(negedge clock);
        readPort(1'b0, v);
        checks++;
        if (v !== mRx || busy !== 1'b1) begin
            errors++; $display("FAIL busy_rx_stable: rx %h busy %b, required %h and 1", v, busy, mRx);
        end
        waitIdle(100);
        mRx = slaveByte;
        checks++;
        if (starts - s0 !== 1) begin errors++; $display("FAIL busy_starts: got %0d, required 1", starts - s0); end
        checks++;
        if (mosiCap !== first) begin errors++; $display("FAIL busy_inflight: got %h, required %h", mosiCap, first); end
        runXfer(3, 8'($urandom)); mRx = slaveByte;
        checks++;
        if (mosiCap !== mTx) begin errors++; $display("FAIL busy_next: got %h, required %h", mosiCap, mTx); end
    endtask

    task automatic test_held_cs();
        logic [7:0] v;
        int s0;
        s0 = starts;
        armSlave(8'($urandom));
        ioWrite(3, 8'h00, 50);
        waitIdle(100);
        repeat (5) @(negedge clock);
        mRx = slaveByte;
        checks++;
        if (starts - s0 !== 1) begin errors++; $display("FAIL held_starts: got %0d, required 1", starts - s0); end
        readPort(1'b0, v);
        checks++;
        if (v !== mRx) begin errors++; $display("FAIL held_rx: got %h, required %h", v, mRx); end
    endtask

    task automatic test_random();
        logic [7:0] v;
        logic [7:0] expMosi;
        int kind;
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                v = 8'($urandom);
                ioWrite(0, v, 2); mTx = v;
            end
            kind = $urandom_range(3, 5);
            expMosi = (kind == 4) ? 8'hFF : mTx;
            runXfer(kind, 8'($urandom)); mRx = slaveByte;
            checks++;
            if (mosiCap !== expMosi || busyCnt !== 16 * (curDiv() + 1) + 1) begin
                errors++; $display("FAIL rand_xfer[%0d]: mosi %h busy %0d, required %h and %0d",
                                   i, mosiCap, busyCnt, expMosi, 16 * (curDiv() + 1) + 1);
            end
            readPort(1'b0, v);
            checks++;
            if (v !== mRx) begin errors++; $display("FAIL rand_rx[%0d]: got %h, required %h", i, v, mRx); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] v;
        int n = 0;
        ioWrite(2, 8'h02, 2); mSelA = 1'b0; mSelB = 1'b1;
        armSlave(8'($urandom));
        ioWrite(3, 8'h00, 1);
        while (rises < 4 && n < 200) begin @(negedge clock); n++; end
        #2 reset_n = 1'b0;
        #1;
        mTx = 8'hFF; mRx = 8'hFF; mFast = 1'b0; mSelA = 1'b0; mSelB = 1'b0;
        checks++;
        if ({busy, spi_sclk, spi_mosi, sd_cs_a_n, sd_cs_b_n} !== 5'b00111) begin
            errors++; $display("FAIL abort_pins: got %b, required 00111",
                               {busy, spi_sclk, spi_mosi, sd_cs_a_n, sd_cs_b_n});
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        readPort(1'b0, v);
        checks++;
        if (v !== mRx) begin errors++; $display("FAIL abort_rx: got %h, required %h", v, mRx); end
        readPort(1'b1, v);
        checks++;
        if (v !== expStatus(1'b0)) begin errors++; $display("FAIL abort_status: got %h, required %h", v, expStatus(1'b0)); end
        ioWrite(1, 8'h01, 2); mFast = 1'b1;
        runXfer(3, 8'($urandom)); mRx = slaveByte;
        readPort(1'b0, v);
        checks++;
        if (mosiCap !== mTx || v !== mRx) begin
            errors++; $display("FAIL abort_clean: mosi %h rx %h, required %h and %h", mosiCap, v, mTx, mRx);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        cpuDataOut = 8'h00;
        DataToSD_cs = 1'b0; DataFmSD_cs = 1'b0; SD_Clk_cs = 1'b0;
        SD_Card_select_cs = 1'b0; SD_status_cs = 1'b0;
        SDWrite_cs = 1'b0; SDRead_cs = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        test_reset();
        test_slow_write();
        test_fast_read();
        test_card_select();
        test_busy_ignore();
        test_held_cs();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
